stall_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core; it sequences the fetch stage by driving the PC/F-D register enable and the D-E bubble insertion. It combines Tuse/Tnew register-dependence stalls with a cycle-accurate busy timer for the multi-cycle multiply/divide unit. It sits beside the D stage. Its enables feed the fetch stage's `D_Enable` input and the D/E pipeline registers.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/md_busy_timer.sv | 49 ++++
 rtl/stall_ctrl.sv | 60 ++++++
 tb/tb_stall_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and defaults for the hazard controller and the MDU busy timer.
package cpu_pkg;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef logic [1:0] tval_t;
  localparam tval_t TUSE_NONE = 2'd3;

  typedef enum logic {MD_IDLE, MD_RUN} md_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide busy timer: loads on E_start and counts down to zero.
module md_busy_timer
  import cpu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic E_start,
  input  logic E_md_div,
  output logic MD_Busy
);
  localparam int CW = $clog2(max2(MULT_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

  md_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A new start always reloads, even mid-count.
  always_comb begin
    cnt_nxt   = cnt;
    state_nxt = state;
    case (state)
      MD_IDLE: begin
        if (E_start) cnt_nxt = E_md_div ? DIV_LD : MULT_LD;
      end
      MD_RUN: begin
        if (E_start)          cnt_nxt = E_md_div ? DIV_LD : MULT_LD;
        else if (cnt != '0)   cnt_nxt = cnt - 1'b1;
      end
      default: cnt_nxt = '0;
    endcase
    state_nxt = (cnt_nxt != '0) ? MD_RUN : MD_IDLE;
  end

  assign MD_Busy = (cnt != '0);
endmodule

// File: rtl/stall_ctrl.sv
// D-stage hazard controller: Tuse/Tnew register stalls plus MDU busy stalls.
module stall_ctrl
  import cpu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  tval_t      D_Tuse_rs,
  input  tval_t      D_Tuse_rt,
  input  logic       D_is_md,
  input  logic [4:0] E_A3,
  input  logic [4:0] M_A3,
  input  tval_t      E_Tnew,
  input  tval_t      M_Tnew,
  input  logic       E_start,
  input  logic       E_md_div,
  output logic       Stall,
  output logic       F_Enable,
  output logic       D_Enable,
  output logic       E_Clear,
  output logic       MD_Busy
);
  localparam int NSRC = 2;

  logic [NSRC-1:0][4:0] src;
  logic [NSRC-1:0][1:0] tuse;
  logic [NSRC-1:0]      reg_hz;
  logic                 md_hz;

  assign src  = {D_rt, D_rs};
  assign tuse = {D_Tuse_rt, D_Tuse_rs};

  // $zero is never a real dependence; TUSE_NONE can't be below any Tnew.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign reg_hz[i] = (src[i] != 5'd0) &&
                       (((E_A3 == src[i]) && (tuse[i] < E_Tnew)) ||
                        ((M_A3 == src[i]) && (tuse[i] < M_Tnew)));
  end

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_timer (
    .clk      (clk),
    .reset    (reset),
    .E_start  (E_start),
    .E_md_div (E_md_div),
    .MD_Busy  (MD_Busy)
  );

  assign md_hz    = D_is_md & (E_start | MD_Busy);
  assign Stall    = (|reg_hz) | md_hz;
  assign F_Enable = ~Stall;
  assign D_Enable = ~Stall;
  assign E_Clear  = Stall;
endmodule

// File: tb/tb_stall_ctrl.sv
// Randomized + directed bench for stall_ctrl against a time-based reference model.
module tb_stall_ctrl;
  import cpu_pkg::*;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0, reset;
  logic [4:0] D_rs, D_rt, E_A3, M_A3;
  tval_t D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic D_is_md, E_start, E_md_div;
  logic Stall, F_Enable, D_Enable, E_Clear, MD_Busy;

  stall_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt),
    .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_is_md(D_is_md),
    .E_A3(E_A3), .M_A3(M_A3), .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
    .E_start(E_start), .E_md_div(E_md_div), .Stall(Stall),
    .F_Enable(F_Enable), .D_Enable(D_Enable), .E_Clear(E_Clear), .MD_Busy(MD_Busy)
  );

  always #5 clk = ~clk;

  int err_cnt = 0, chk_cnt = 0;
  int edge_n = 0, busy_end = 0;
  logic last_stall, last_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: the MDU is busy until a known edge number.
  function automatic bit m_busy();
    return edge_n < busy_end;
  endfunction

  function automatic bit m_dep(input int r, input int tu);
    if (r == 0) return 0;
    if (r == int'(E_A3) && tu < int'(E_Tnew)) return 1;
    if (r == int'(M_A3) && tu < int'(M_Tnew)) return 1;
    return 0;
  endfunction

  // Called #1 after an edge with inputs set; checks mid-cycle, then advances one edge.
  task automatic step();
    bit es;
    #3;
    es = m_dep(D_rs, D_Tuse_rs) || m_dep(D_rt, D_Tuse_rt) ||
         (D_is_md && (E_start || m_busy()));
    chk("stall", Stall, es);
    chk("f_en", F_Enable, !es);
    chk("d_en", D_Enable, !es);
    chk("e_clr", E_Clear, es);
    chk("busy", MD_Busy, m_busy());
    last_stall = Stall;
    last_busy  = MD_Busy;
    @(posedge clk);
    edge_n++;
    if (E_start) busy_end = edge_n + (E_md_div ? DC : MC);
    #1;
  endtask

  task automatic clr_in();
    D_rs = 0; D_rt = 0; D_Tuse_rs = TUSE_NONE; D_Tuse_rt = TUSE_NONE; D_is_md = 0;
    E_A3 = 0; M_A3 = 0; E_Tnew = 0; M_Tnew = 0; E_start = 0; E_md_div = 0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    clr_in();
    D_Tuse_rs = 0; D_Tuse_rt = 0;
    @(posedge clk); #1;
    chk("rst_busy", MD_Busy, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_eclr", E_Clear, 0);
    chk("rst_fen", F_Enable, 1);
    chk("rst_den", D_Enable, 1);
    reset = 1'b0;
    clr_in();
    step();

    // Load-use on rs, then producer one stage closer
    E_A3 = 8; E_Tnew = 2; D_rs = 8; D_Tuse_rs = 1;
    step();
    chk("lu_stall", last_stall, 1);
    E_Tnew = 1;
    step();
    chk("lu_clear", last_stall, 0);

    // $zero guard
    clr_in(); D_rt = 0; E_A3 = 0; E_Tnew = 2; D_Tuse_rt = 0;
    step();
    chk("zero_guard", last_stall, 0);

    // Mult timer: start cycle + MC busy cycles stall
    clr_in(); D_is_md = 1; E_start = 1; E_md_div = 0;
    n = 0;
    step(); n += last_stall;
    E_start = 0;
    repeat (MC) begin step(); n += last_stall; end
    chk("mult_stall_cyc", n, MC + 1);
    step();
    chk("mult_done", last_busy, 0);

    // Div timer busy length
    clr_in(); E_start = 1; E_md_div = 1;
    step();
    E_start = 0; n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!last_busy) break;
      n++;
    end
    chk("div_busy_cyc", n, DC);

    // Div then mult reload at busy cycle 4
    E_start = 1; E_md_div = 1;
    step();
    E_start = 0;
    repeat (3) step();
    E_start = 1; E_md_div = 0;
    step();
    E_start = 0; n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!last_busy) break;
      n++;
    end
    chk("reload_busy_cyc", n, MC);

    // Simultaneous M-stage hazard and running timer
    clr_in(); D_is_md = 1; E_start = 1;
    M_A3 = 5; M_Tnew = 1; D_rs = 5; D_Tuse_rs = 0;
    step();
    E_start = 0;
    repeat (2) step();
    M_A3 = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!last_stall) break;
      n++;
    end
    chk("simul_tail", n, MC - 2);

    // Reset mid-count
    clr_in(); E_start = 1; E_md_div = 1;
    step();
    E_start = 0;
    repeat (3) step();
    reset = 1'b1; #1;
    busy_end = 0; edge_n = 0;
    chk("rst_mid_busy", MD_Busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    D_is_md = 1;
    step();
    chk("rst_mid_stall", last_stall, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
      D_Tuse_rs = 2'($urandom); D_Tuse_rt = 2'($urandom);
      E_A3 = 5'($urandom_range(0, 3)); M_A3 = 5'($urandom_range(0, 3));
      E_Tnew = 2'($urandom); M_Tnew = 2'($urandom);
      D_is_md = ($urandom_range(0, 2) == 0);
      E_start = ($urandom_range(0, 7) == 0);
      E_md_div = 1'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
